// File: rtl/seg_pkg.sv
// Shared types and constants for the decimal entry/accumulator: FSM states,
// button indices and the active-low 7-segment pattern table.
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CONV,
        ADD,
        DONE
    } state_e;

    localparam int unsigned BTN_NEXT = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned BTN_DEC  = 2;
    localparam int unsigned NUM_BTN  = 3;

    // Segment order {g,f,e,d,c,b,a}, low = lit.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [7:0] SEG_ZERO = 8'hC0;

    // Non-decimal codes cannot occur in the digit register but still blank safely.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic dp_on);
        logic [6:0] glyph;
        glyph = (digit <= 4'd9) ? SEG_LUT[digit] : 7'h7F;
        return {~dp_on, glyph};
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw active-low button, debounces it and emits a single-cycle
// pulse on each accepted press (accepted high-to-low transition).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_BITS = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_ni,
    output logic press_o
);

    logic [1:0]               sync_q;
    logic                     cand_q;
    logic                     stable_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q;
    logic                     press_q;

    // cand_q tracks the most recent synchronised level; the counter measures how long
    // it has been steady and stable_q only follows once the count has saturated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= 2'b11;
            cand_q   <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_ni};
            press_q <= 1'b0;
            if (sync_q[1] != cand_q) begin
                cand_q <= sync_q[1];
                cnt_q  <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
            end else if (stable_q != cand_q) begin
                stable_q <= cand_q;
                press_q  <= ~cand_q;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/bcd_entry_accum.sv
// N-digit decimal entry from three push-buttons with sequential BCD-to-binary
// conversion, replace/saturating-accumulate update and registered 7-seg output.
module bcd_entry_accum
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned DEBOUNCE_BITS = 4,
    parameter int unsigned VAL_W         = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            btn,
    input  logic                  mode,
    output logic [8*DIGITS-1:0]   seg,
    output logic [VAL_W-1:0]      value,
    output logic                  value_valid,
    output logic                  sat,
    output logic                  busy
);

    localparam int unsigned CUR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CUR_W-1:0] CUR_MSD = CUR_W'(DIGITS - 1);

    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
        $error("bcd_entry_accum: DIGITS must be in 1..8");
    end
    if ((64'd1 << VAL_W) <= (pow10(DIGITS) - 64'd1)) begin : g_bad_width
        $error("bcd_entry_accum: VAL_W too narrow for DIGITS decimal digits");
    end

    // ---------------------------------------------------------------- buttons
    logic [NUM_BTN-1:0] press;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_debounce (
            .clk_i  (clk),
            .rst_i  (rst),
            .btn_ni (btn[b]),
            .press_o(press[b])
        );
    end

    logic ev_next;
    logic ev_inc;
    logic ev_dec;

    assign ev_next = press[BTN_NEXT];
    assign ev_inc  = press[BTN_INC];
    assign ev_dec  = press[BTN_DEC];

    // ---------------------------------------------------------------- state
    state_e                state_q;
    logic [4*DIGITS-1:0]   digits_q;
    logic [CUR_W-1:0]      cursor_q;
    logic [CUR_W-1:0]      conv_idx_q;
    logic [VAL_W-1:0]      acc_q;
    logic                  mode_q;
    logic [VAL_W-1:0]      value_q;
    logic                  valid_q;
    logic                  sat_q;
    logic [8*DIGITS-1:0]   seg_q;

    // ---------------------------------------------------------------- datapath
    logic [3:0]       cur_digit;
    logic [3:0]       digit_up;
    logic [3:0]       digit_dn;
    logic [3:0]       conv_digit;
    logic [VAL_W-1:0] acc_next;
    logic [VAL_W:0]   sum;

    always_comb begin
        cur_digit  = digits_q[4*cursor_q +: 4];
        digit_up   = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
        digit_dn   = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
        conv_digit = digits_q[4*conv_idx_q +: 4];
        // acc*10 as acc*8 + acc*2; the result always fits since VAL_W covers 10**DIGITS-1.
        acc_next   = (acc_q << 3) + (acc_q << 1) + VAL_W'(conv_digit);
        sum        = {1'b0, value_q} + {1'b0, acc_q};
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            digits_q   <= '0;
            cursor_q   <= CUR_MSD;
            conv_idx_q <= CUR_MSD;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (ev_next) begin
                        state_q  <= ENTRY;
                        digits_q <= '0;
                        cursor_q <= CUR_MSD;
                    end
                end
                ENTRY: begin
                    // A next press swallows any inc/dec arriving in the same cycle.
                    if (ev_next) begin
                        if (cursor_q == '0) begin
                            mode_q     <= mode;
                            acc_q      <= '0;
                            conv_idx_q <= CUR_MSD;
                            state_q    <= CONV;
                        end else begin
                            cursor_q <= cursor_q - CUR_W'(1);
                        end
                    end else if (ev_inc && !ev_dec) begin
                        digits_q[4*cursor_q +: 4] <= digit_up;
                    end else if (ev_dec && !ev_inc) begin
                        digits_q[4*cursor_q +: 4] <= digit_dn;
                    end
                end
                CONV: begin
                    acc_q <= acc_next;
                    if (conv_idx_q == '0) begin
                        state_q <= ADD;
                    end else begin
                        conv_idx_q <= conv_idx_q - CUR_W'(1);
                    end
                end
                ADD: begin
                    if (mode_q) begin
                        value_q <= sum[VAL_W] ? '1 : sum[VAL_W-1:0];
                        sat_q   <= sum[VAL_W];
                    end else begin
                        value_q <= acc_q;
                        sat_q   <= 1'b0;
                    end
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- display
    logic [8*DIGITS-1:0] seg_d;

    always_comb begin
        seg_d = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            seg_d[8*i +: 8] = seg_encode(digits_q[4*i +: 4],
                                         (state_q == ENTRY) && (cursor_q == CUR_W'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= {DIGITS{SEG_ZERO}};
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign sat         = sat_q;
    assign busy        = (state_q == CONV) || (state_q == ADD);

endmodule

// File: tb/tb_bcd_entry_accum.sv
// Directed bench for bcd_entry_accum: stimulus pushes expected commit results into a
// queue and a monitor checks them, plus commit latency, whenever value_valid fires.
module tb_bcd_entry_accum;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned VAL_W  = 14;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2:0]          btn = 3'b111;
    logic                mode = 1'b0;
    logic [8*DIGITS-1:0] seg;
    logic [VAL_W-1:0]    value;
    logic                value_valid;
    logic                sat;
    logic                busy;

    bcd_entry_accum #(
        .DIGITS       (DIGITS),
        .DEBOUNCE_BITS(4),
        .VAL_W        (VAL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .mode       (mode),
        .seg        (seg),
        .value      (value),
        .value_valid(value_valid),
        .sat        (sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic             sat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rise_cyc = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: busy rising marks the cycle after the commit event.
    always @(negedge clk) begin
        if (busy && !busy_prev) rise_cyc = cyc;
        busy_prev = busy;
        if (value_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got value %0d, expected no pulse", value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("value", 64'(value), 64'(e.value));
                chk("sat", 64'(sat), 64'(e.sat));
                chk("latency", 64'(cyc - rise_cyc), 64'(DIGITS + 1));
            end
        end
    end

    // mask bits set = buttons pressed (driven low).
    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        btn = ~mask;
        repeat (24) @(negedge clk);
        btn = 3'b111;
        repeat (24) @(negedge clk);
    endtask

    task automatic press_n(input logic [2:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        btn = 3'b111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // From IDLE/DONE: enter 9999 with dec-wraps and commit.
    task automatic commit_9999(input exp_t e, input bit check_seg);
        press(3'b001);
        for (int d = 0; d < 4; d++) begin
            press(3'b100);
            if (d == 3) begin
                if (check_seg) chk("seg_9999", 64'(seg), 64'h90909010);
                sb.push_back(e);
            end
            press(3'b001);
        end
        wait_done("commit_9999");
    endtask

    initial begin
        int k;
        // 1. reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", 64'(seg), 64'hC0C0C0C0);
        chk("rst_value", 64'(value), 64'd0);
        chk("rst_valid", 64'(value_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);

        // 2. replace with 1052
        mode = 1'b0;
        press(3'b001);
        chk("entry_seg", 64'(seg), 64'h40C0C0C0);
        press(3'b010);
        press(3'b001);
        press(3'b001);
        press_n(3'b010, 5);
        press(3'b001);
        press_n(3'b010, 2);
        chk("seg_1052", 64'(seg), 64'hF9C09224);
        sb.push_back('{value: 14'd1052, sat: 1'b0});
        press(3'b001);
        wait_done("t2");

        // 3. accumulate 0048
        press(3'b001);
        mode = 1'b1;
        press(3'b001);
        press(3'b001);
        press_n(3'b010, 4);
        press(3'b001);
        press_n(3'b010, 8);
        chk("seg_0048", 64'(seg), 64'hC0C09900);
        sb.push_back('{value: 14'd1100, sat: 1'b0});
        press(3'b001);
        wait_done("t3");

        // 4. wrap and priority
        press(3'b001);
        press_n(3'b010, 10);
        chk("inc_wrap", 64'(seg), 64'h40C0C0C0);
        press(3'b100);
        chk("dec_wrap", 64'(seg), 64'h10C0C0C0);
        press(3'b110);
        chk("inc_dec_same", 64'(seg), 64'h10C0C0C0);
        press(3'b011);
        chk("next_inc_same", 64'(seg), 64'h9040C0C0);

        // 5. saturation
        pulse_rst();
        chk("rst2_value", 64'(value), 64'd0);
        mode = 1'b1;
        commit_9999('{value: 14'd9999, sat: 1'b0}, 1'b1);
        commit_9999('{value: 14'd16383, sat: 1'b1}, 1'b0);
        commit_9999('{value: 14'd16383, sat: 1'b1}, 1'b0);

        // 6. bounce, then abort mid-conversion
        press(3'b001);
        @(negedge clk);
        btn = 3'b101;
        repeat (10) @(negedge clk);
        btn = 3'b111;
        repeat (40) @(negedge clk);
        chk("bounce_ignored", 64'(seg), 64'h40C0C0C0);
        press_n(3'b001, 3);
        @(negedge clk);
        btn = 3'b110;
        k = 0;
        while (!busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("busy_seen", 64'(busy), 64'd1);
        rst = 1'b1;
        btn = 3'b111;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_value", 64'(value), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sat", 64'(sat), 64'd0);
        chk("abort_seg", 64'(seg), 64'hC0C0C0C0);
        repeat (30) @(negedge clk);
        press(3'b010);
        chk("idle_drops_inc", 64'(seg), 64'hC0C0C0C0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
